// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package fetch_pkg;
    localparam int          INST_W  = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, inst} pairs with first-word-fall-through head
// and a single-cycle flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);
    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count masks stale entries.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch requester: owns the PC, issues imem reads under a credit
// rule so every in-flight word has a FIFO slot, and flushes on redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_stop,
    input  logic [31:0] i_imem_data,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_inst_ready
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic          inflight_q, inflight_d;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          pop, push, issue;
    fetch_entry_t  head, push_data;

    assign o_inst_valid = !rst && !i_redirect_valid && (count != '0);
    assign o_inst       = o_inst_valid ? head.inst : '0;
    assign o_inst_pc    = o_inst_valid ? head.pc   : '0;
    assign pop          = o_inst_valid & i_inst_ready;

    // A pop this cycle frees a slot for the word issued now, which lands in two
    // cycles; that is what lets ready->stop resume fetch without a bubble.
    assign occupancy   = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue       = !rst && !i_redirect_valid && (occupancy < (CW+1)'(DEPTH));
    assign o_imem_stop = !issue;
    assign o_imem_addr = pc_q;

    assign push           = inflight_q & !i_redirect_valid;
    assign push_data.pc   = inflight_pc_q;
    assign push_data.inst = i_imem_data;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (i_redirect_valid) begin
            pc_d = i_redirect_pc & ~32'd3;
        end else if (issue) begin
            pc_d          = pc_q + PC_STEP;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (i_redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: directed phases push expected PCs, negedge
// monitors compare every accepted instruction against the queues.
module tb_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance, RESET_PC = 0
    logic        rst, rv, stop0, valid0, rdy;
    logic [31:0] rpc, addr0, inst0, ipc0;
    logic [31:0] imem0 = '0;

    // second instance, RESET_PC near the top of the address space
    logic        rst1, stop1, valid1, rdy1;
    logic [31:0] addr1, inst1, ipc1;
    logic [31:0] imem1 = '0;
    logic        rv1 = 1'b0;
    logic [31:0] rpc1 = '0;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp1_q[$];
    logic [31:0] e0, e1;

    fetch_unit u_dut (
        .clk(clk), .rst(rst), .i_redirect_valid(rv), .i_redirect_pc(rpc),
        .o_imem_addr(addr0), .o_imem_stop(stop0), .i_imem_data(imem0),
        .o_inst_valid(valid0), .o_inst(inst0), .o_inst_pc(ipc0), .i_inst_ready(rdy)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
        .clk(clk), .rst(rst1), .i_redirect_valid(rv1), .i_redirect_pc(rpc1),
        .o_imem_addr(addr1), .o_imem_stop(stop1), .i_imem_data(imem1),
        .o_inst_valid(valid1), .o_inst(inst1), .o_inst_pc(ipc1), .i_inst_ready(rdy1)
    );

    // imem: registered read, word = address, output held while stopped
    always @(posedge clk) if (!stop0) imem0 <= addr0;
    always @(posedge clk) if (!stop1) imem1 <= addr1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && valid0 && rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL u0 unexpected output: got pc %h expected none", ipc0);
            end else begin
                e0 = exp_q.pop_front();
                chk("u0 pc", ipc0, e0);
                chk("u0 inst", inst0, e0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst1 && valid1 && rdy1) begin
            if (exp1_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL u1 unexpected output: got pc %h expected none", ipc1);
            end else begin
                e1 = exp1_q.pop_front();
                chk("u1 pc", ipc1, e1);
                chk("u1 inst", inst1, e1);
            end
        end
    end

    initial begin
        rst = 1'b1; rst1 = 1'b1; rdy = 1'b1; rdy1 = 1'b1; rv = 1'b0; rpc = '0;
        tick(); tick(); #2;
        chk("rst valid", 32'(valid0), 32'd0);
        chk("rst inst", inst0, 32'd0);
        chk("rst inst_pc", ipc0, 32'd0);
        chk("rst stop", 32'(stop0), 32'd1);
        chk("rst addr", addr0, 32'd0);

        // A: streaming with ready high, then reset with one entry buffered
        tick(); rst = 1'b0;                                         // c0
        foreach (exp_q[i]) exp_q.delete(i);
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        #2;
        chk("A c0 addr", addr0, 32'd0);
        chk("A c0 stop", 32'(stop0), 32'd0);
        chk("A c0 valid", 32'(valid0), 32'd0);
        tick(); #2; chk("A c1 addr", addr0, 32'd4);                 // c1
        tick(); #2; chk("A c2 valid", 32'(valid0), 32'd1);          // c2
        repeat (5) tick();                                          // c7
        tick(); rdy = 1'b0; rst = 1'b1; #2;                         // c8
        chk("A rst valid", 32'(valid0), 32'd0);
        chk("A rst stop", 32'(stop0), 32'd1);
        tick(); #2;                                                 // c9
        chk("A post-rst valid", 32'(valid0), 32'd0);
        chk("A post-rst addr", addr0, 32'd0);
        chk("A post-rst stop", 32'(stop0), 32'd1);
        chk("A post-rst inst_pc", ipc0, 32'd0);
        chk("A drained", 32'(exp_q.size()), 32'd0);

        // B: back-pressure for 6 cycles after first valid
        tick(); rst = 1'b0; rdy = 1'b1;                             // c0
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        #2; chk("B c0 addr", addr0, 32'd0);
        tick();                                                     // c1
        tick(); rdy = 1'b0; #2;                                     // c2
        chk("B c2 valid", 32'(valid0), 32'd1);
        chk("B c2 inst_pc", ipc0, 32'd0);
        chk("B c2 stop", 32'(stop0), 32'd1);
        chk("B c2 addr", addr0, 32'd8);
        repeat (5) tick(); #2;                                      // c7
        chk("B c7 stop", 32'(stop0), 32'd1);
        chk("B c7 addr", addr0, 32'd8);
        chk("B c7 inst_pc", ipc0, 32'd0);
        tick(); rdy = 1'b1; #2;                                     // c8
        chk("B resume stop", 32'(stop0), 32'd0);
        chk("B resume addr", addr0, 32'd8);
        tick(); #2; chk("B c9 inst_pc", ipc0, 32'd4);
        tick(); #2; chk("B c10 inst_pc", ipc0, 32'd8);
        tick(); rdy = 1'b0; rst = 1'b1;                             // c11
        tick();
        chk("B drained", 32'(exp_q.size()), 32'd0);

        // C: redirect with FIFO full, then back-to-back redirects
        tick(); rst = 1'b0; rdy = 1'b0;                             // c0
        exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
        exp_q.push_back(32'h300); exp_q.push_back(32'h304); exp_q.push_back(32'h308);
        repeat (4) tick(); #2;                                      // c4
        chk("C full valid", 32'(valid0), 32'd1);
        chk("C full stop", 32'(stop0), 32'd1);
        tick(); rv = 1'b1; rpc = 32'h0000_0103; #2;                 // c5
        chk("C redir valid", 32'(valid0), 32'd0);
        chk("C redir stop", 32'(stop0), 32'd1);
        tick(); rv = 1'b0; rdy = 1'b1; #2;                          // c6
        chk("C c6 addr", addr0, 32'h100);
        chk("C c6 stop", 32'(stop0), 32'd0);
        chk("C c6 valid", 32'(valid0), 32'd0);
        tick(); #2;                                                 // c7
        chk("C c7 valid", 32'(valid0), 32'd0);
        chk("C c7 addr", addr0, 32'h104);
        tick(); #2;                                                 // c8
        chk("C c8 valid", 32'(valid0), 32'd1);
        chk("C c8 inst_pc", ipc0, 32'h100);
        tick(); tick();                                             // c10
        tick(); rv = 1'b1; rpc = 32'h200; #2;                       // c11
        chk("D c11 valid", 32'(valid0), 32'd0);
        chk("D c11 stop", 32'(stop0), 32'd1);
        tick(); rpc = 32'h300; #2;                                  // c12
        chk("D c12 valid", 32'(valid0), 32'd0);
        chk("D c12 addr", addr0, 32'h200);
        chk("D c12 stop", 32'(stop0), 32'd1);
        tick(); rv = 1'b0; #2;                                      // c13
        chk("D c13 addr", addr0, 32'h300);
        chk("D c13 stop", 32'(stop0), 32'd0);
        tick(); #2; chk("D c14 valid", 32'(valid0), 32'd0);
        tick(); #2;                                                 // c15
        chk("D c15 valid", 32'(valid0), 32'd1);
        chk("D c15 inst_pc", ipc0, 32'h300);
        tick(); tick();                                             // c17
        tick(); rdy = 1'b0;                                         // c18
        tick(); #2;
        chk("CD drained", 32'(exp_q.size()), 32'd0);

        // E: PC wrap from the top of the address space
        tick(); rst1 = 1'b0;                                        // c0
        exp1_q.push_back(32'hFFFF_FFF8); exp1_q.push_back(32'hFFFF_FFFC);
        exp1_q.push_back(32'h0000_0000); exp1_q.push_back(32'h0000_0004);
        #2; chk("E c0 addr", addr1, 32'hFFFF_FFF8);
        tick(); #2; chk("E c1 addr", addr1, 32'hFFFF_FFFC);
        tick(); #2; chk("E c2 addr", addr1, 32'h0000_0000);
        repeat (3) tick();                                          // c5
        tick(); rdy1 = 1'b0; rst1 = 1'b1;                           // c6
        tick(); #2;
        chk("E drained", 32'(exp1_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
